tone_step_sequencer: RTL and testbench
======================================

// Module: tone_step_sequencer
// PURPOSE
//  Sequences the programmable clock divider (11-bit scale_factor, async-reset) as a
//  tone generator. Holds a small table of {scale, duration} steps, plays them in order,
//  and drives the divider's scale_factor and reset. Sits between the config/pin
//  interface and the divider instance in the audio path.
// PARAMETERS
//  STEPS     8     table depth, power of two; step index width IW = log2(STEPS)
//  SCALE_W   11    width of scale entry and scale_factor output
//  DUR_W     8     width of duration entry, in ticks
//  TICK_DIV  1000  clk cycles per duration tick, >= 1
// PORTS
//  clk           in   1        system clock
//  rst           in   1        reset, synchronous, active-high
//  wr_en         in   1        table write strobe
//  wr_addr       in   IW       table write index
//  wr_scale      in   SCALE_W  scale value to write; 0 = rest step
//  wr_dur        in   DUR_W    duration to write; 0 = end-of-sequence marker
//  start         in   1        1-cycle pulse: begin playing at step 0
//  stop          in   1        1-cycle pulse: abort playback
//  loop          in   1        1 = wrap from last step to step 0; sampled at each wrap
//  scale_factor  out  SCALE_W  registered; to divider scale input
//  div_rst       out  1        registered; to divider rst; high = divider held/muted
//  busy          out  1        high in LOAD or PLAY
//  step_idx      out  IW       index of step being loaded/played
//  done          out  1        1-cycle pulse when sequence ends (end marker or last step, no loop)
// BEHAVIOUR
//  Reset: state IDLE; table entries all 0; scale_factor=0, div_rst=1, busy=0,
//   step_idx=0, done=0, tick counter=0, duration counter=0.
//  FSM states: IDLE, LOAD, PLAY.
//   IDLE: div_rst=1. start -> LOAD, step_idx=0.
//   LOAD (exactly 1 cycle): read table[step_idx].
//    - dur==0: -> IDLE, done=1 next cycle, div_rst stays 1.
//    - otherwise: scale_factor<=scale, div_rst<=(scale==0), tick counter and
//      duration counter cleared -> PLAY.
//   PLAY: tick counter counts 0..TICK_DIV-1; a tick fires on wrap; duration counter
//    increments per tick. When it reaches dur:
//    - step_idx != STEPS-1: step_idx+1, -> LOAD.
//    - step_idx == STEPS-1 and loop=1: step_idx=0, -> LOAD.
//    - step_idx == STEPS-1 and loop=0: -> IDLE, done=1, div_rst=1.
//  Step timing: 1 LOAD cycle + dur*TICK_DIV PLAY cycles; LOAD is muted (div_rst=1),
//   so the divider restarts phase-aligned on every step.
//  stop: in any state -> IDLE next cycle; div_rst=1, busy=0; done NOT asserted;
//   scale_factor holds its last value.
//  stop and start in the same cycle: stop wins.
//  start while busy (without stop): ignored.
//  Table writes are accepted in every state. A write to the step in PLAY does not
//   change current outputs; it takes effect at that step's next LOAD.
//   A write in the same cycle as the LOAD of that address: LOAD reads the old value.
//  Counter widths: tick counter holds TICK_DIV-1; duration counter is DUR_W bits,
//   so max dur (2^DUR_W-1) must not overflow.
//  All outputs are registered, so div_rst is glitch-free on the divider's async reset.
//  Reset mid-playback has the same effect as power-on reset, including clearing the table.
// TESTING  (TICK_DIV=4, STEPS=8)
//  1 Write {100,2},{200,1},{x,0} at 0..2; start -> scale 100 for 8 cycles, LOAD,
//    scale 200 for 4 cycles, LOAD, done pulse, div_rst=1, busy=0.
//  2 Step 1 = {0,3} (rest) -> div_rst=1 for 1+12 cycles while busy=1; next step unmutes.
//  3 All 8 steps dur=1, loop=1 -> step_idx wraps 7->0, no done. Drop loop before the
//    wrap -> done after step 7.
//  4 stop mid-PLAY -> IDLE next cycle, div_rst=1, no done. start+stop together -> stays IDLE.
//  5 During step 0 PLAY, rewrite step 0 to {300,1}; start after the end -> first play
//    unchanged, second play uses 300. Repeated start while busy has no effect.
//  6 Assert rst mid-PLAY -> all outputs at reset values on the next edge; table reads
//    0, so a later start ends immediately with a done pulse.

Source files
------------

// File: rtl/tone_step_sequencer_if.sv
// Config/pin-side bundle of the tone sequencer: table writes, play controls, divider drive.
// The sequencer uses the slave modport; whoever programs and triggers it uses master.
interface tone_step_sequencer_if #(
    parameter int STEPS   = 8,
    parameter int SCALE_W = 11,
    parameter int DUR_W   = 8
);
    localparam int IW = $clog2(STEPS);

    logic               wr_en;
    logic [IW-1:0]      wr_addr;
    logic [SCALE_W-1:0] wr_scale;
    logic [DUR_W-1:0]   wr_dur;
    logic               start;
    logic               stop;
    logic               loop;
    logic [SCALE_W-1:0] scale_factor;
    logic               div_rst;
    logic               busy;
    logic [IW-1:0]      step_idx;
    logic               done;

    modport master (
        output wr_en, wr_addr, wr_scale, wr_dur, start, stop, loop,
        input  scale_factor, div_rst, busy, step_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_scale, wr_dur, start, stop, loop,
        output scale_factor, div_rst, busy, step_idx, done
    );
endinterface

// File: rtl/tone_step_sequencer.sv
// Plays a table of {scale, duration} steps into a clock divider's scale_factor and reset.
// Outputs registered (one cycle after the deciding edge); no backpressure, table writes always accepted.
module tone_step_sequencer #(
    parameter int STEPS    = 8,
    parameter int SCALE_W  = 11,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    tone_step_sequencer_if.slave bus
);
    localparam int IW = $clog2(STEPS);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(STEPS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    typedef struct packed {
        logic [SCALE_W-1:0] scale;
        logic [DUR_W-1:0]   dur;
    } step_t;

    state_t             state_q, state_d;
    step_t              table_q [STEPS];
    step_t              table_d [STEPS];
    step_t              cur_entry;
    logic [IW-1:0]      step_idx_q, step_idx_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d, dur_cnt_inc;
    logic [TW-1:0]      tick_q, tick_d;
    logic               div_rst_q, div_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Writes land on the next edge, so a LOAD in the same cycle still sees the old entry.
    always_comb begin
        for (int i = 0; i < STEPS; i++) table_d[i] = table_q[i];
        if (bus.wr_en) table_d[bus.wr_addr] = '{scale: bus.wr_scale, dur: bus.wr_dur};
    end

    always_comb begin
        state_d     = state_q;
        step_idx_d  = step_idx_q;
        scale_d     = scale_q;
        dur_d       = dur_q;
        dur_cnt_d   = dur_cnt_q;
        tick_d      = tick_q;
        div_rst_d   = div_rst_q;
        done_d      = 1'b0;
        cur_entry   = table_q[step_idx_q];
        dur_cnt_inc = dur_cnt_q + DUR_W'(1);

        case (state_q)
            S_IDLE: begin
                div_rst_d = 1'b1;
                if (bus.start) begin
                    state_d    = S_LOAD;
                    step_idx_d = '0;
                end
            end
            S_LOAD: begin
                if (cur_entry.dur == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_PLAY;
                    scale_d   = cur_entry.scale;
                    dur_d     = cur_entry.dur;
                    div_rst_d = (cur_entry.scale == '0);
                    tick_d    = '0;
                    dur_cnt_d = '0;
                end
            end
            S_PLAY: begin
                tick_d = tick_q + TW'(1);
                if (tick_q == TICK_LAST) begin
                    tick_d    = '0;
                    dur_cnt_d = dur_cnt_inc;
                    if (dur_cnt_inc == dur_q) begin
                        // LOAD is muted so the divider restarts phase-aligned on every step.
                        div_rst_d = 1'b1;
                        if (step_idx_q != LAST_IDX) begin
                            step_idx_d = step_idx_q + IW'(1);
                            state_d    = S_LOAD;
                        end else if (bus.loop) begin
                            step_idx_d = '0;
                            state_d    = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats everything, including a same-cycle start or end-of-sequence.
        if (bus.stop) begin
            state_d    = S_IDLE;
            step_idx_d = step_idx_q;
            scale_d    = scale_q;
            div_rst_d  = 1'b1;
            done_d     = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
            step_idx_q <= '0;
            scale_q    <= '0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            tick_q     <= '0;
            div_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < STEPS; i++) table_q[i] <= table_d[i];
            step_idx_q <= step_idx_d;
            scale_q    <= scale_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            tick_q     <= tick_d;
            div_rst_q  <= div_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.scale_factor = scale_q;
    assign bus.div_rst      = div_rst_q;
    assign bus.busy         = busy_q;
    assign bus.step_idx     = step_idx_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_tone_step_sequencer.sv
// Bench for tone_step_sequencer: directed scenarios with literal expectations plus random
// stimulus, all outputs compared every cycle against a cycles-remaining playback model.
module tb_tone_step_sequencer;
    localparam int STEPS    = 8;
    localparam int SCALE_W  = 11;
    localparam int DUR_W    = 8;
    localparam int TICK_DIV = 4;
    localparam int IW       = $clog2(STEPS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tone_step_sequencer_if #(.STEPS(STEPS), .SCALE_W(SCALE_W), .DUR_W(DUR_W)) bus ();

    tone_step_sequencer #(
        .STEPS(STEPS), .SCALE_W(SCALE_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 load, 2 play; a step plays for dur*TICK_DIV cycles.
    int  m_mode, m_idx, m_left, m_scale;
    bit  m_mute, m_done, m_valid;
    int  tbl_s [STEPS];
    int  tbl_d [STEPS];

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_idx = 0; m_left = 0; m_scale = 0;
            m_mute = 1'b1; m_done = 1'b0; m_valid = 1'b1;
            for (int i = 0; i < STEPS; i++) begin tbl_s[i] = 0; tbl_d[i] = 0; end
        end else begin
            m_done = 1'b0;
            if (bus.stop) begin
                m_mode = 0;
                m_mute = 1'b1;
            end else if (m_mode == 0) begin
                if (bus.start) begin m_mode = 1; m_idx = 0; end
            end else if (m_mode == 1) begin
                if (tbl_d[m_idx] == 0) begin
                    m_mode = 0; m_done = 1'b1;
                end else begin
                    m_scale = tbl_s[m_idx];
                    m_mute  = (m_scale == 0);
                    m_left  = tbl_d[m_idx] * TICK_DIV;
                    m_mode  = 2;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mute = 1'b1;
                    if (m_idx < STEPS - 1) begin m_idx++; m_mode = 1; end
                    else if (bus.loop) begin m_idx = 0; m_mode = 1; end
                    else begin m_mode = 0; m_done = 1'b1; end
                end
            end
            if (bus.wr_en) begin
                tbl_s[int'(bus.wr_addr)] = int'(bus.wr_scale);
                tbl_d[int'(bus.wr_addr)] = int'(bus.wr_dur);
            end
        end
        #1;
        if (m_valid) begin
            check("model scale_factor", int'(bus.scale_factor), m_scale);
            check("model div_rst", int'(bus.div_rst), int'(m_mute));
            check("model busy", int'(bus.busy), (m_mode != 0) ? 1 : 0);
            check("model step_idx", int'(bus.step_idx), m_idx);
            check("model done", int'(bus.done), int'(m_done));
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int s, input int d);
        bus.wr_en = 1'b1; bus.wr_addr = IW'(a); bus.wr_scale = SCALE_W'(s); bus.wr_dur = DUR_W'(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_scale = '0; bus.wr_dur = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        rst = 1'b1;
        adv(3);
        check("reset scale", int'(bus.scale_factor), 0);
        check("reset div_rst", int'(bus.div_rst), 1);
        check("reset busy", int'(bus.busy), 0);
        check("reset step_idx", int'(bus.step_idx), 0);
        check("reset done", int'(bus.done), 0);
        rst = 1'b0;

        // Two tones then an end marker.
        wr(0, 100, 2); wr(1, 200, 1); wr(2, 123, 0);
        pulse_start();
        check("t1 load busy", int'(bus.busy), 1);
        check("t1 load muted", int'(bus.div_rst), 1);
        adv(1);
        check("t1 step0 scale", int'(bus.scale_factor), 100);
        check("t1 step0 unmuted", int'(bus.div_rst), 0);
        adv(7);
        check("t1 step0 last cycle", int'(bus.scale_factor), 100);
        adv(1);
        check("t1 step1 load muted", int'(bus.div_rst), 1);
        check("t1 step1 idx", int'(bus.step_idx), 1);
        adv(1);
        check("t1 step1 scale", int'(bus.scale_factor), 200);
        adv(4);
        check("t1 end marker idx", int'(bus.step_idx), 2);
        adv(1);
        check("t1 done", int'(bus.done), 1);
        check("t1 idle busy", int'(bus.busy), 0);
        adv(1);
        check("t1 done one cycle", int'(bus.done), 0);

        // Rest step in the middle.
        wr(0, 50, 1); wr(1, 0, 3); wr(2, 70, 1); wr(3, 0, 0);
        pulse_start();
        adv(17);
        check("t2 rest muted", int'(bus.div_rst), 1);
        check("t2 rest busy", int'(bus.busy), 1);
        check("t2 rest scale", int'(bus.scale_factor), 0);
        adv(2);
        check("t2 after rest scale", int'(bus.scale_factor), 70);
        check("t2 after rest unmuted", int'(bus.div_rst), 0);
        adv(10);

        // Full table, looping, then loop dropped.
        for (int i = 0; i < STEPS; i++) wr(i, i * 10 + 1, 1);
        bus.loop = 1'b1;
        pulse_start();
        adv(40);
        check("t3 wrapped idx", int'(bus.step_idx), 0);
        check("t3 wrapped busy", int'(bus.busy), 1);
        adv(10);
        bus.loop = 1'b0;
        adv(30);
        check("t3 done after step7", int'(bus.done), 1);
        check("t3 idle", int'(bus.busy), 0);
        adv(2);

        // Stop mid-play; start and stop together.
        pulse_start();
        adv(2);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("t4 stop busy", int'(bus.busy), 0);
        check("t4 stop muted", int'(bus.div_rst), 1);
        check("t4 stop no done", int'(bus.done), 0);
        check("t4 stop holds scale", int'(bus.scale_factor), 1);
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("t4 start+stop idle", int'(bus.busy), 0);
        adv(2);

        // Rewrite of the playing step, start while busy, write during LOAD.
        wr(0, 40, 2); wr(1, 0, 0);
        pulse_start();
        adv(2);
        wr(0, 300, 1);
        pulse_start();
        adv(4);
        check("t5 first play scale", int'(bus.scale_factor), 40);
        check("t5 first play busy", int'(bus.busy), 1);
        adv(2);
        check("t5 first play done", int'(bus.done), 1);
        pulse_start();
        wr(0, 500, 3);
        check("t5 second play scale", int'(bus.scale_factor), 300);
        adv(5);
        check("t5 second play done", int'(bus.done), 1);
        adv(2);

        // Reset mid-play clears the table.
        pulse_start();
        adv(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 rst scale", int'(bus.scale_factor), 0);
        check("t6 rst div_rst", int'(bus.div_rst), 1);
        check("t6 rst busy", int'(bus.busy), 0);
        pulse_start();
        adv(1);
        check("t6 empty table done", int'(bus.done), 1);
        adv(2);

        // Maximum duration.
        wr(0, 5, 255);
        pulse_start();
        adv(1020);
        check("max dur last cycle", int'(bus.scale_factor), 5);
        check("max dur still playing", int'(bus.div_rst), 0);
        adv(1);
        check("max dur next idx", int'(bus.step_idx), 1);
        adv(1);
        check("max dur done", int'(bus.done), 1);

        for (int c = 0; c < 6000; c++) begin
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = IW'($urandom_range(0, STEPS - 1));
            bus.wr_scale = ($urandom_range(0, 3) == 0) ? '0 : SCALE_W'($urandom_range(1, 2047));
            bus.wr_dur   = ($urandom_range(0, 7) == 0) ? '0 : DUR_W'($urandom_range(1, 3));
            bus.start    = ($urandom_range(0, 19) == 0);
            bus.stop     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 49) == 0) bus.loop = ~bus.loop;
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        bus.wr_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0;
        adv(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
